// File: rtl/clock_reset_sequencer.sv
// Staggered reset-release sequencer for NUM_DOMAINS downstream domains, with valid/ready re-reset requests.
// Optional clock gating around each domain's reset window is built when RESET_SEQ_CLKGATE_EN is defined.
module clock_reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD        = 8,
  parameter int STAGGER     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [NUM_DOMAINS-1:0] req_mask,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic [NUM_DOMAINS-1:0] domain_clock_en,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             debug_state
);

  localparam int MAX_CNT = (HOLD > STAGGER) ? HOLD : STAGGER;
  localparam int CW = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);
  // A release is visible in the RELEASE cycle itself, so the gap between releases is STAGGER-1 GAP cycles.
  localparam logic [CW-1:0] GAP_LOAD = CW'((STAGGER >= 2) ? (STAGGER - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_RELEASE = 3'd2,
    S_GAP     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Handshake: a request transfers on a clock edge where req_valid && req_ready; req_ready is high only in IDLE.
  state_t                 state;
  state_t                 next_state;
  logic [CW-1:0]          count;
  logic [NUM_DOMAINS-1:0] pending;
  logic [NUM_DOMAINS-1:0] lowest;
  logic                   accept;
  logic                   release_now;

  assign accept      = req_valid && req_ready;
  assign lowest      = pending & (~pending + NUM_DOMAINS'(1));
  assign release_now = (next_state == S_RELEASE);
  assign debug_state = state;

  always_ff @(posedge clock) begin
    if (reset) state <= S_HOLD;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (accept) next_state = (|req_mask) ? S_HOLD : S_DONE;
      S_HOLD:    if (count == '0) next_state = S_RELEASE;
      S_RELEASE: begin
        if (pending == '0)     next_state = S_DONE;
        else if (STAGGER == 1) next_state = S_RELEASE;
        else                   next_state = S_GAP;
      end
      S_GAP:     if (count == '0) next_state = S_RELEASE;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Reset preloads the state of an all-ones accept, so power-on is just the normal sequence.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending      <= '1;
      count        <= HOLD_LOAD;
      domain_reset <= '1;
    end else begin
      if (state == S_IDLE && accept && (|req_mask)) begin
        domain_reset <= domain_reset | req_mask;
        pending      <= req_mask;
        count        <= HOLD_LOAD;
      end
      if (release_now) begin
        domain_reset <= domain_reset & ~lowest;
        pending      <= pending & ~lowest;
      end
      if (state == S_RELEASE && next_state == S_GAP) count <= GAP_LOAD;
      if ((state == S_HOLD || state == S_GAP) && count != '0) count <= count - CW'(1);
    end
  end

`ifdef RESET_SEQ_CLKGATE_EN
  localparam logic [CW-1:0] EN_POINT = CW'(2);
  logic [NUM_DOMAINS-1:0] clk_en_q;

  // Enables reopen two cycles before the first release; later domains idle in GAP with clocks running.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_en_q <= '0;
    end else if (state == S_IDLE && accept) begin
      clk_en_q <= clk_en_q & ~req_mask;
    end else if (state == S_HOLD && count == EN_POINT) begin
      clk_en_q <= clk_en_q | pending;
    end
  end

  assign domain_clock_en = clk_en_q;
`else
  assign domain_clock_en = '1;
`endif

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Bench for clock_reset_sequencer: vector table, chained and mid-sequence reset cases, and random masks
// checked against a release-schedule model derived from HOLD/STAGGER arithmetic.
module tb_clock_reset_sequencer;
  localparam int N       = 4;
  localparam int HOLD    = 8;
  localparam int STAGGER = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [N-1:0] req_mask = '0;
  logic [N-1:0] domain_reset;
  logic [N-1:0] domain_clock_en;
  logic         busy;
  logic         done;
  logic [2:0]   debug_state;

  clock_reset_sequencer #(.NUM_DOMAINS(N), .HOLD(HOLD), .STAGGER(STAGGER)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_mask(req_mask), .domain_reset(domain_reset), .domain_clock_en(domain_clock_en),
    .busy(busy), .done(done), .debug_state(debug_state)
  );

  // Clock/reset and cycle count
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cycle %0d actual running required finished", cyc);
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0] mask;
    int           done_off;
    bit           chain;
    logic [N-1:0] next_mask;
  } vec_t;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual 0x%0h required 0x%0h", name, c, act, exp);
    end
  endtask

  task automatic reset_chk();
    chk("rst_domain_reset", cyc, 32'(domain_reset), 32'hF);
    chk("rst_busy", cyc, 32'(busy), 32'd1);
    chk("rst_ready", cyc, 32'(req_ready), 32'd0);
    chk("rst_done", cyc, 32'(done), 32'd0);
`ifdef RESET_SEQ_CLKGATE_EN
    chk("rst_clock_en", cyc, 32'(domain_clock_en), 32'h0);
`else
    chk("rst_clock_en", cyc, 32'(domain_clock_en), 32'hF);
`endif
  endtask

  // Driver: present a request in the next IDLE cycle; t is the cycle whose closing edge accepts it.
  task automatic issue(input logic [N-1:0] m, output int t);
    int waited;
    waited = 0;
    @(negedge clock);
    while (!req_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    chk("issue_ready", cyc, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_mask  = m;
    t = cyc;
  endtask

  // Model: the j-th set bit (ascending) releases at t+1+HOLD+j*STAGGER; done follows the last release.
  task automatic check_seq(input logic [N-1:0] m, input int t, input int done_off,
                           input bit chain, input logic [N-1:0] next_m, output int last);
    int rel[N];
    int j;
    int done_seen;
    logic [N-1:0] er;
    logic [N-1:0] ee;
    j = 0;
    done_seen = -1;
    last = t;
    for (int i = 0; i < N; i++) begin
      rel[i] = 0;
      if (m[i]) begin
        rel[i] = t + 1 + HOLD + j * STAGGER;
        last = rel[i];
        j++;
      end
    end
    for (int c = t + 1; c <= last + 2; c++) begin
      for (int i = 0; i < N; i++) er[i] = m[i] && (c < rel[i]);
      exp_q.push_back(er);
    end
    for (int c = t + 1; c <= last + 2; c++) begin
      while (cyc < c) @(negedge clock);
      er = exp_q.pop_front();
      chk("domain_reset", c, 32'(domain_reset), 32'(er));
      chk("busy", c, 32'(busy), 32'(c <= last + 1));
      chk("done", c, 32'(done), 32'(c == last + 1));
      chk("req_ready", c, 32'(req_ready), 32'(c == last + 2));
`ifdef RESET_SEQ_CLKGATE_EN
      for (int i = 0; i < N; i++) ee[i] = !(m[i] && c <= t + HOLD - 2);
`else
      ee = '1;
`endif
      chk("clock_en", c, 32'(domain_clock_en), 32'(ee));
      if (done && done_seen < 0) done_seen = c;
      if (c == t + 1) begin
        if (chain) req_mask = next_m;
        else begin
          req_valid = 1'b0;
          req_mask  = N'($urandom_range(0, 15));
        end
      end
    end
    if (done_off >= 0) chk("done_cycle", t, 32'(done_seen), 32'(t + done_off));
  endtask

  vec_t vecs[6];
  int   t;
  int   last;
  int   base;
  bit   chained;
  logic [N-1:0] m;

  initial begin
    vecs[0] = '{mask: 4'b1010, done_off: 26, chain: 1'b0, next_mask: 4'b0000};
    vecs[1] = '{mask: 4'b0000, done_off: 1,  chain: 1'b0, next_mask: 4'b0000};
    vecs[2] = '{mask: 4'b0001, done_off: 10, chain: 1'b0, next_mask: 4'b0000};
    vecs[3] = '{mask: 4'b1111, done_off: 58, chain: 1'b0, next_mask: 4'b0000};
    vecs[4] = '{mask: 4'b0110, done_off: 26, chain: 1'b1, next_mask: 4'b1001};
    vecs[5] = '{mask: 4'b1001, done_off: 26, chain: 1'b0, next_mask: 4'b0000};

    // Reset values, then power-on sequence (cycle 0 = first cycle with reset low)
    repeat (2) @(negedge clock);
    reset_chk();
    @(negedge clock);
    reset_chk();
    reset = 1'b0;
    base = cyc;
    check_seq(4'b1111, base - 1, 58, 1'b0, 4'b0000, last);

    // Table-driven requests, including a request held valid across a busy sequence
    chained = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!chained) issue(vecs[k].mask, t);
      else t = last + 2;
      check_seq(vecs[k].mask, t, vecs[k].done_off, vecs[k].chain, vecs[k].next_mask, last);
      chained = vecs[k].chain;
    end

    // Randomized masks with random idle spacing
    repeat (6) begin
      m = N'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) @(negedge clock);
      issue(m, t);
      check_seq(m, t, -1, 1'b0, 4'b0000, last);
    end

    // Reset pulsed during the first GAP of a full-mask sequence
    issue(4'b1111, t);
    @(negedge clock);
    req_valid = 1'b0;
    while (cyc < t + 15) @(negedge clock);
    chk("gap_domain_reset", cyc, 32'(domain_reset), 32'hE);
    reset = 1'b1;
    @(negedge clock);
    reset_chk();
    @(negedge clock);
    reset_chk();
    reset = 1'b0;
    base = cyc;
    check_seq(4'b1111, base - 1, 58, 1'b0, 4'b0000, last);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
